// File: rtl/crt_sync_measure.sv
// crt_sync_measure: measures external hsync/vsync timing and publishes
// one result set (period/width/polarity, lines, valid, lock) per frame.
// Ports: clk, reset (sync, high), extsyncon (enable, low = clear),
//   hsync, vsync (async) in; h_period, h_width, h_pol, v_lines, v_width,
//   v_pol, valid, lock, lost, frame_stb out.
module crt_sync_measure #(
  parameter int HCNT_W      = 12,
  parameter int VCNT_W      = 10,
  parameter int HTOL        = 2,
  parameter int LOCK_FRAMES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              extsyncon,
  input  logic              hsync,
  input  logic              vsync,
  output logic [HCNT_W-1:0] h_period,
  output logic [HCNT_W-1:0] h_width,
  output logic              h_pol,
  output logic [VCNT_W-1:0] v_lines,
  output logic [VCNT_W-1:0] v_width,
  output logic              v_pol,
  output logic              valid,
  output logic              lock,
  output logic              lost,
  output logic              frame_stb
);

  localparam logic [HCNT_W-1:0] HMAX   = '1;
  localparam logic [VCNT_W-1:0] VMAX   = '1;
  localparam logic [HCNT_W-1:0] HONE   = HCNT_W'(1);
  localparam logic [VCNT_W-1:0] VONE   = VCNT_W'(1);
  localparam logic [HCNT_W-1:0] HTOL_V = HCNT_W'(HTOL);
  localparam logic [3:0]        LOCK_N = 4'(LOCK_FRAMES);

  logic clr;
  assign clr = reset | ~extsyncon;

  logic hs_s1_q, hs_s2_q, hs_s3_q, hs_s1_d, hs_s2_d, hs_s3_d;
  logic vs_s1_q, vs_s2_q, vs_s3_q, vs_s1_d, vs_s2_d, vs_s3_d;
  logic hrise_q, hrise_d, vrise_q, vrise_d;
  logic [1:0] fill_q, fill_d;

  logic [HCNT_W-1:0] hh_cnt_q, hh_cnt_d, hl_cnt_q, hl_cnt_d;
  logic [HCNT_W-1:0] lh_q, lh_d, ll_q, ll_d;
  logic [VCNT_W-1:0] vh_cnt_q, vh_cnt_d, vl_cnt_q, vl_cnt_d;
  logic [1:0]        hseen_q, hseen_d;
  logic              vseen_q, vseen_d;
  logic              frame_sat_q, frame_sat_d;

  logic [HCNT_W-1:0] h_period_q, h_period_d, h_width_q, h_width_d;
  logic [VCNT_W-1:0] v_lines_q, v_lines_d, v_width_q, v_width_d;
  logic              h_pol_q, h_pol_d, v_pol_q, v_pol_d;
  logic              valid_q, valid_d, lock_q, lock_d;
  logic              lost_q, lost_d, frame_stb_q, frame_stb_d;
  logic [3:0]        match_cnt_q, match_cnt_d;

  logic [HCNT_W:0]   hsum;
  logic [VCNT_W:0]   vsum;
  logic [HCNT_W-1:0] cap_lh, cap_ll, pub_hp, hdiff;
  logic [VCNT_W-1:0] pub_vl;
  logic              pub_valid, match, sat_now;

  always_comb begin
    hs_s1_d     = hsync;
    hs_s2_d     = hs_s1_q;
    hs_s3_d     = hs_s2_q;
    vs_s1_d     = vsync;
    vs_s2_d     = vs_s1_q;
    vs_s3_d     = vs_s2_q;
    fill_d      = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    // Cleared synchroniser flops would fake a rise on a high input;
    // edges count only once the third flop holds a real sample.
    hrise_d     = (fill_q == 2'd3) & hs_s2_q & ~hs_s3_q;
    vrise_d     = (fill_q == 2'd3) & vs_s2_q & ~vs_s3_q;

    hh_cnt_d    = hh_cnt_q;
    hl_cnt_d    = hl_cnt_q;
    lh_d        = lh_q;
    ll_d        = ll_q;
    vh_cnt_d    = vh_cnt_q;
    vl_cnt_d    = vl_cnt_q;
    hseen_d     = hseen_q;
    vseen_d     = vseen_q;
    h_period_d  = h_period_q;
    h_width_d   = h_width_q;
    h_pol_d     = h_pol_q;
    v_lines_d   = v_lines_q;
    v_width_d   = v_width_q;
    v_pol_d     = v_pol_q;
    valid_d     = valid_q;
    lock_d      = lock_q;
    lost_d      = lost_q;
    match_cnt_d = match_cnt_q;
    frame_stb_d = vrise_q;

    // The rise cycle is itself a high clock, so hh restarts at 1.
    if (hrise_q) begin
      lh_d     = hh_cnt_q;
      ll_d     = hl_cnt_q;
      hh_cnt_d = HONE;
      hl_cnt_d = '0;
      if (hseen_q != 2'd2) hseen_d = hseen_q + 2'd1;
    end else if (hs_s3_q) begin
      if (hh_cnt_q != HMAX) hh_cnt_d = hh_cnt_q + HONE;
    end else begin
      if (hl_cnt_q != HMAX) hl_cnt_d = hl_cnt_q + HONE;
    end

    // A coincident hsync rise belongs to the new frame.
    if (vrise_q) begin
      vh_cnt_d = VCNT_W'(hrise_q);
      vl_cnt_d = '0;
      vseen_d  = 1'b1;
    end else if (hrise_q) begin
      if (vs_s3_q) begin
        if (vh_cnt_q != VMAX) vh_cnt_d = vh_cnt_q + VONE;
      end else begin
        if (vl_cnt_q != VMAX) vl_cnt_d = vl_cnt_q + VONE;
      end
    end

    // Same-cycle horizontal capture is part of this publication.
    cap_lh = hrise_q ? hh_cnt_q : lh_q;
    cap_ll = hrise_q ? hl_cnt_q : ll_q;
    hsum   = {1'b0, cap_lh} + {1'b0, cap_ll};
    pub_hp = hsum[HCNT_W] ? HMAX : hsum[HCNT_W-1:0];
    vsum   = {1'b0, vh_cnt_q} + {1'b0, vl_cnt_q};
    pub_vl = vsum[VCNT_W] ? VMAX : vsum[VCNT_W-1:0];
    hdiff  = (pub_hp >= h_period_q) ? pub_hp - h_period_q
                                    : h_period_q - pub_hp;

    sat_now = (hh_cnt_q == HMAX) | (hl_cnt_q == HMAX) |
              (vh_cnt_q == VMAX) | (vl_cnt_q == VMAX);
    frame_sat_d = frame_sat_q | sat_now;

    pub_valid = (hseen_q == 2'd2) & vseen_q & ~frame_sat_d;
    match     = pub_valid & valid_q & (hdiff <= HTOL_V) &
                (pub_vl == v_lines_q);

    if (sat_now) begin
      lost_d      = 1'b1;
      valid_d     = 1'b0;
      lock_d      = 1'b0;
      match_cnt_d = '0;
    end

    if (vrise_q) begin
      h_period_d  = pub_hp;
      h_width_d   = (cap_lh <= cap_ll) ? cap_lh : cap_ll;
      h_pol_d     = (cap_lh <= cap_ll);
      v_lines_d   = pub_vl;
      v_width_d   = (vh_cnt_q < vl_cnt_q) ? vh_cnt_q : vl_cnt_q;
      v_pol_d     = (vh_cnt_q < vl_cnt_q);
      valid_d     = pub_valid;
      lost_d      = frame_sat_d;
      frame_sat_d = 1'b0;
      if (!match)
        match_cnt_d = '0;
      else if (match_cnt_q != LOCK_N)
        match_cnt_d = match_cnt_q + 4'd1;
      else
        match_cnt_d = match_cnt_q;
      lock_d = (match_cnt_d == LOCK_N);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hs_s1_q     <= 1'b0;
      hs_s2_q     <= 1'b0;
      hs_s3_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vs_s3_q     <= 1'b0;
      hrise_q     <= 1'b0;
      vrise_q     <= 1'b0;
      fill_q      <= '0;
      hh_cnt_q    <= '0;
      hl_cnt_q    <= '0;
      lh_q        <= '0;
      ll_q        <= '0;
      vh_cnt_q    <= '0;
      vl_cnt_q    <= '0;
      hseen_q     <= '0;
      vseen_q     <= 1'b0;
      frame_sat_q <= 1'b0;
      h_period_q  <= '0;
      h_width_q   <= '0;
      h_pol_q     <= 1'b0;
      v_lines_q   <= '0;
      v_width_q   <= '0;
      v_pol_q     <= 1'b0;
      valid_q     <= 1'b0;
      lock_q      <= 1'b0;
      lost_q      <= 1'b0;
      match_cnt_q <= '0;
      frame_stb_q <= 1'b0;
    end else begin
      hs_s1_q     <= hs_s1_d;
      hs_s2_q     <= hs_s2_d;
      hs_s3_q     <= hs_s3_d;
      vs_s1_q     <= vs_s1_d;
      vs_s2_q     <= vs_s2_d;
      vs_s3_q     <= vs_s3_d;
      hrise_q     <= hrise_d;
      vrise_q     <= vrise_d;
      fill_q      <= fill_d;
      hh_cnt_q    <= hh_cnt_d;
      hl_cnt_q    <= hl_cnt_d;
      lh_q        <= lh_d;
      ll_q        <= ll_d;
      vh_cnt_q    <= vh_cnt_d;
      vl_cnt_q    <= vl_cnt_d;
      hseen_q     <= hseen_d;
      vseen_q     <= vseen_d;
      frame_sat_q <= frame_sat_d;
      h_period_q  <= h_period_d;
      h_width_q   <= h_width_d;
      h_pol_q     <= h_pol_d;
      v_lines_q   <= v_lines_d;
      v_width_q   <= v_width_d;
      v_pol_q     <= v_pol_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      lost_q      <= lost_d;
      match_cnt_q <= match_cnt_d;
      frame_stb_q <= frame_stb_d;
    end
  end

  assign h_period  = h_period_q;
  assign h_width   = h_width_q;
  assign h_pol     = h_pol_q;
  assign v_lines   = v_lines_q;
  assign v_width   = v_width_q;
  assign v_pol     = v_pol_q;
  assign valid     = valid_q;
  assign lock      = lock_q;
  assign lost      = lost_q;
  assign frame_stb = frame_stb_q;

endmodule

// File: tb/tb_crt_sync_measure.sv
// tb_crt_sync_measure: directed bench for crt_sync_measure using
// scaled frames (312 lines, short lines) with hand-computed results.
module tb_crt_sync_measure;

  logic        clk = 1'b0;
  logic        reset, extsyncon, hsync, vsync;
  logic [11:0] h_period, h_width;
  logic [9:0]  v_lines, v_width;
  logic        h_pol, v_pol, valid, lock, lost, frame_stb;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int stb_long = 0;
  logic stb_prev = 1'b0;

  always #5 clk = ~clk;

  crt_sync_measure dut (
    .clk(clk), .reset(reset), .extsyncon(extsyncon),
    .hsync(hsync), .vsync(vsync),
    .h_period(h_period), .h_width(h_width), .h_pol(h_pol),
    .v_lines(v_lines), .v_width(v_width), .v_pol(v_pol),
    .valid(valid), .lock(lock), .lost(lost), .frame_stb(frame_stb)
  );

  always @(negedge clk) begin
    if (frame_stb) begin
      stb_cnt++;
      if (stb_prev) stb_long++;
    end
    stb_prev = frame_stb;
  end

  // Line l of a 312-line frame: h pulse for hw clocks at line start,
  // v pulse covers lines 0..3 starting/ending at clock voff.
  task automatic run_lines(input int l0, input int l1, input int hp,
                           input int hw, input bit hinv,
                           input bit vinv, input int voff);
    for (int l = l0; l < l1; l++) begin
      for (int c = 0; c < hp; c++) begin
        logic hact, vact;
        @(negedge clk);
        hact = (c < hw);
        vact = (l == 0 && c >= voff) || l == 1 || l == 2 ||
               (l == 3 && c < voff);
        hsync = hact ^ hinv;
        vsync = vinv ? vact : !vact;
      end
    end
  endtask

  task automatic run_frame(input int hp, input int hw, input bit hinv,
                           input bit vinv, input int voff);
    run_lines(0, 312, hp, hw, hinv, vinv, voff);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    extsyncon = 1'b1;
    hsync = 1'b0;
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({h_period, h_width, h_pol, v_lines, v_width, v_pol,
         valid, lock, lost, frame_stb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h want 0",
               {h_period, h_width, v_lines, v_width});
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_nominal;
    int s;
    s = stb_cnt;
    run_frame(8, 2, 0, 0, 5);
    checks++;
    if (stb_cnt - s !== 1) begin
      errors++;
      $display("FAIL nom_stb1: got %0d strobes want 1", stb_cnt - s);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL nom_valid1: got %0b want 0", valid);
    end
    run_frame(8, 2, 0, 0, 5);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL nom_valid2: got %0b want 1", valid);
    end
    checks++;
    if (h_period !== 12'd8) begin
      errors++;
      $display("FAIL nom_h_period: got %0d want 8", h_period);
    end
    checks++;
    if (h_width !== 12'd2) begin
      errors++;
      $display("FAIL nom_h_width: got %0d want 2", h_width);
    end
    checks++;
    if (h_pol !== 1'b1) begin
      errors++;
      $display("FAIL nom_h_pol: got %0b want 1", h_pol);
    end
    checks++;
    if (v_lines !== 10'd312) begin
      errors++;
      $display("FAIL nom_v_lines: got %0d want 312", v_lines);
    end
    checks++;
    if (v_width !== 10'd3) begin
      errors++;
      $display("FAIL nom_v_width: got %0d want 3", v_width);
    end
    checks++;
    if (v_pol !== 1'b0) begin
      errors++;
      $display("FAIL nom_v_pol: got %0b want 0", v_pol);
    end
    checks++;
    if (lock !== 1'b0 || lost !== 1'b0) begin
      errors++;
      $display("FAIL nom_lock_lost: got %0b%0b want 00", lock, lost);
    end
  endtask

  task automatic test_lock;
    for (int f = 3; f <= 4; f++) begin
      run_frame(8, 2, 0, 0, 5);
      checks++;
      if (lock !== 1'b0) begin
        errors++;
        $display("FAIL lock_early_f%0d: got %0b want 0", f, lock);
      end
    end
    run_frame(8, 2, 0, 0, 5);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL lock_rise: got %0b want 1", lock);
    end
  endtask

  task automatic test_jitter;
    run_frame(10, 2, 0, 0, 5);
    checks++;
    if (lock !== 1'b1 || h_period !== 12'd10) begin
      errors++;
      $display("FAIL jit_plus2: got lock %0b per %0d want 1 10",
               lock, h_period);
    end
    run_frame(8, 2, 0, 0, 5);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL jit_minus2: got lock %0b want 1", lock);
    end
    run_frame(11, 2, 0, 0, 5);
    checks++;
    if (lock !== 1'b0 || h_period !== 12'd11) begin
      errors++;
      $display("FAIL jit_plus3: got lock %0b per %0d want 0 11",
               lock, h_period);
    end
  endtask

  task automatic test_inverted;
    repeat (3) run_frame(8, 2, 1, 1, 5);
    checks++;
    if (h_pol !== 1'b0 || v_pol !== 1'b1) begin
      errors++;
      $display("FAIL inv_pol: got %0b%0b want 01", h_pol, v_pol);
    end
    checks++;
    if (h_period !== 12'd8 || h_width !== 12'd2) begin
      errors++;
      $display("FAIL inv_h: got %0d/%0d want 8/2", h_period, h_width);
    end
    checks++;
    if (v_lines !== 10'd312 || v_width !== 10'd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL inv_v: got %0d/%0d v%0b want 312/3 v1",
               v_lines, v_width, valid);
    end
  endtask

  task automatic test_loss;
    repeat (2) run_frame(8, 2, 0, 0, 5);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL loss_pre_valid: got %0b want 1", valid);
    end
    run_lines(0, 100, 8, 2, 0, 0, 5);
    repeat (4100) begin
      @(negedge clk);
      hsync = 1'b0;
    end
    checks++;
    if (lost !== 1'b1 || valid !== 1'b0 || lock !== 1'b0) begin
      errors++;
      $display("FAIL loss_flags: got lost %0b valid %0b lock %0b want 100",
               lost, valid, lock);
    end
    checks++;
    if (h_period !== 12'd8 || h_width !== 12'd2 || v_lines !== 10'd312) begin
      errors++;
      $display("FAIL loss_hold: got %0d/%0d/%0d want 8/2/312",
               h_period, h_width, v_lines);
    end
    run_lines(100, 312, 8, 2, 0, 0, 5);
    run_frame(8, 2, 0, 0, 5);
    checks++;
    if (lost !== 1'b1) begin
      errors++;
      $display("FAIL loss_partial: got lost %0b want 1", lost);
    end
    run_frame(8, 2, 0, 0, 5);
    checks++;
    if (lost !== 1'b0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL loss_clear: got lost %0b valid %0b want 0 1",
               lost, valid);
    end
  endtask

  task automatic test_reset_enable;
    int s;
    run_lines(0, 100, 8, 2, 0, 0, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({h_period, h_width, h_pol, v_lines, v_width, v_pol,
         valid, lock, lost, frame_stb} !== '0) begin
      errors++;
      $display("FAIL rst_mid_zero: got %0h want 0",
               {h_period, h_width, v_lines, v_width});
    end
    reset = 1'b0;
    run_lines(100, 312, 8, 2, 0, 0, 5);
    s = stb_cnt;
    run_frame(8, 2, 0, 0, 5);
    checks++;
    if (stb_cnt - s !== 1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_stb: got %0d stb valid %0b want 1 0",
               stb_cnt - s, valid);
    end
    run_lines(0, 100, 8, 2, 0, 0, 5);
    @(negedge clk);
    extsyncon = 1'b0;
    @(negedge clk);
    checks++;
    if ({h_period, h_width, h_pol, v_lines, v_width, v_pol,
         valid, lock, lost, frame_stb} !== '0) begin
      errors++;
      $display("FAIL en_mid_zero: got %0h want 0",
               {h_period, h_width, v_lines, v_width});
    end
    repeat (2) @(negedge clk);
    extsyncon = 1'b1;
    run_lines(100, 312, 8, 2, 0, 0, 5);
    s = stb_cnt;
    run_frame(8, 2, 0, 0, 5);
    checks++;
    if (stb_cnt - s !== 1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL en_first_stb: got %0d stb valid %0b want 1 0",
               stb_cnt - s, valid);
    end
  endtask

  task automatic test_simultaneous;
    repeat (2) run_frame(8, 2, 0, 0, 0);
    checks++;
    if (v_lines !== 10'd312 || v_width !== 10'd3 || v_pol !== 1'b0) begin
      errors++;
      $display("FAIL sim_v: got %0d/%0d/%0b want 312/3/0",
               v_lines, v_width, v_pol);
    end
    checks++;
    if (h_period !== 12'd8 || valid !== 1'b1) begin
      errors++;
      $display("FAIL sim_h: got %0d valid %0b want 8 1",
               h_period, valid);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock();
    test_jitter();
    test_inverted();
    test_loss();
    test_reset_enable();
    test_simultaneous();
    checks++;
    if (stb_long !== 0) begin
      errors++;
      $display("FAIL stb_one_cycle: got %0d long strobes want 0",
               stb_long);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
